// File: rtl/countdown_sched_pkg.sv
// countdown_sched_pkg
//   Shared definitions for the countdown scheduler:
//   - sched_state_e : FSM state encoding (IDLE, LOAD, COUNT, DONE)
//   - NREQ_DEF      : default number of requesters
//   - W_DEF         : default width of the shared down counter
//   - idx_w()       : width of a requester index (at least 1 bit)
package countdown_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // A single requester still needs a 1-bit index so that vectors are never
  // zero width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/countdown_sched_if.sv
// countdown_sched_if
//   Bundles the requester-side signals of the countdown scheduler.
//   Parameters: NREQ (requesters), W (count width).
//   Signals:
//     req     [NREQ]   level requests, one bit per requester
//     ldvalue [NREQ*W] start counts, requester i on [i*W +: W]
//     grant   [NREQ]   one-hot requester being served, zero when idle
//     busy             high whenever the scheduler is not idle
//     done    [NREQ]   one-cycle pulse on the requester that finished
//     dout    [W]      current value of the shared down counter
//     state            FSM state, exported for debug and checkers
//   Handshake: req is a level request, not a valid/ready pair. A request is
//   only looked at while the scheduler is idle; once granted, the service
//   runs to completion whatever req does, and done marks the end. A
//   requester that still holds req afterwards simply competes again.
//   Modports: master = requester side (drives req/ldvalue),
//             slave  = scheduler side (drives grant/busy/done/dout/state).
interface countdown_sched_if #(
  parameter int NREQ = countdown_sched_pkg::NREQ_DEF,
  parameter int W    = countdown_sched_pkg::W_DEF
);
  import countdown_sched_pkg::*;

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] ldvalue;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      dout;
  sched_state_e      state;

  modport master (
    output req, ldvalue,
    input  grant, busy, done, dout, state
  );

  modport slave (
    input  req, ldvalue,
    output grant, busy, done, dout, state
  );

endinterface

// File: rtl/sched_down_cnt.sv
// sched_down_cnt
//   Loadable down counter shared by all requesters.
//   Ports:
//     clk     clock
//     rst     asynchronous active-high reset, clears dout to 0
//     ld      load ldvalue (has priority over en)
//     en      decrement by one
//     ldvalue start value
//     dout    current count
module sched_down_cnt #(
  parameter int W = countdown_sched_pkg::W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         en,
  input  logic [W-1:0] ldvalue,
  output logic [W-1:0] dout
);
  import countdown_sched_pkg::*;

  // The zero guard keeps the count from wrapping to all-ones even if en is
  // left high at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (ld) begin
      dout <= ldvalue;
    end else if (en && (dout != '0)) begin
      dout <= dout - W'(1);
    end
  end

endmodule

// File: rtl/countdown_sched.sv
// countdown_sched
//   Round-robin scheduler granting one requester at a time a countdown
//   service on a shared down counter.
//   Ports:
//     clk  clock
//     rst  asynchronous active-high reset
//     bus  countdown_sched_if.slave: req/ldvalue in; grant/busy/done/dout/
//          state out
//   Parameters NREQ and W must match those of the connected interface.
//   Service timeline for a request sampled in IDLE at edge T with start
//   count N: LOAD after T, counter = N after T+1, counter = 0 after T+1+N,
//   DONE after T+2+N, back in IDLE after T+3+N.
module countdown_sched #(
  parameter int NREQ = countdown_sched_pkg::NREQ_DEF,
  parameter int W    = countdown_sched_pkg::W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  countdown_sched_if.slave  bus
);
  import countdown_sched_pkg::*;

  localparam int IW = idx_w(NREQ);

  sched_state_e    state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            cnt_ld, cnt_en;
  logic [W-1:0]    cnt_ldvalue;
  logic [W-1:0]    cnt_val;

  // (base + off) mod NREQ, valid for off < NREQ; works for any NREQ,
  // not only powers of two.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base,
                                             input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IW-1:0];
  endfunction

  // Round-robin pick: first set req bit at or after ptr, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_valid && bus.req[wrap_idx(ptr_q, i)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(ptr_q, i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and datapath controls.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_ld  = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_LOAD;
          grant_d = NREQ'(1) << pick_idx;
          gidx_d  = pick_idx;
        end
      end
      ST_LOAD: begin
        cnt_ld  = 1'b1;
        state_d = ST_COUNT;
      end
      ST_COUNT: begin
        // A zero count still spends this one cycle here before DONE.
        if (cnt_val != '0) begin
          cnt_en = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        ptr_d   = wrap_idx(gidx_q, 1);
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Grant, granted index and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign cnt_ldvalue = bus.ldvalue[int'(gidx_q) * W +: W];

  sched_down_cnt #(.W(W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .ld      (cnt_ld),
    .en      (cnt_en),
    .ldvalue (cnt_ldvalue),
    .dout    (cnt_val)
  );

  // done and busy decode straight from the state register, so reset clears
  // them without waiting for a clock edge.
  assign bus.grant = grant_q;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = (state_q == ST_DONE) ? grant_q : '0;
  assign bus.dout  = cnt_val;
  assign bus.state = state_q;

endmodule

// File: tb/tb_countdown_sched.sv
// tb_countdown_sched
//   Directed and randomized bench for countdown_sched. A service-level model
//   tracks which requester is being served and how many edges have passed
//   since its grant, and derives every expected output from the service
//   timeline.
module tb_countdown_sched;
  import countdown_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  countdown_sched_if #(.NREQ(NREQ), .W(W)) bus ();

  countdown_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [NREQ-1:0] req_v;
  logic [W-1:0]    ldv [NREQ];

  assign bus.req = req_v;
  always_comb begin
    bus.ldvalue = '0;
    for (int i = 0; i < NREQ; i++) bus.ldvalue[i*W +: W] = ldv[i];
  end

  // ---------------- reference model ----------------
  bit m_active;   // a service is in progress
  int m_g;        // requester being served
  int m_k;        // edges since the grant edge
  int m_n;        // start count, taken at the load edge
  int m_ptr;      // round-robin start point

  function automatic int pick_next(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return 0;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_active = 1'b0;
      m_ptr    = 0;
    end else if (m_active) begin
      m_k++;
      if (m_k == 1) m_n = int'(ldv[m_g]);
      // Edge leaving DONE: requests are not looked at on this edge.
      if (m_k >= 1 && m_k == m_n + 3) begin
        m_active = 1'b0;
        m_ptr    = (m_g + 1) % NREQ;
      end
    end else if (req_v != '0) begin
      m_g      = pick_next(req_v, m_ptr);
      m_active = 1'b1;
      m_k      = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] eg, edone;
    logic            ebusy;
    logic [W-1:0]    edout;
    sched_state_e    est;
    eg    = '0;
    edone = '0;
    ebusy = 1'b0;
    edout = '0;
    est   = ST_IDLE;
    if (m_active) begin
      eg[m_g] = 1'b1;
      ebusy   = 1'b1;
      if (m_k == 0) begin
        est = ST_LOAD;
      end else if (m_k <= m_n + 1) begin
        est   = ST_COUNT;
        edout = W'(m_n - (m_k - 1));
      end else begin
        est   = ST_DONE;
        edone = eg;
      end
    end
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("busy",  32'(bus.busy),  32'(ebusy));
    chk("done",  32'(bus.done),  32'(edone));
    chk("dout",  32'(bus.dout),  32'(edout));
    chk("state", 32'(bus.state), 32'(est));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: update the model at the edge, compare at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && m_active; i++) step();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    m_active = 1'b0;
    m_ptr    = 0;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_dout",  32'(bus.dout),  32'd0);
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  logic [NREQ-1:0] exp_q[$];
  logic [NREQ-1:0] obs_q[$];
  logic [NREQ-1:0] prev_grant;

  initial begin
    total  = 0;
    bad    = 0;
    req_v  = '0;
    for (int i = 0; i < NREQ; i++) ldv[i] = '0;
    m_active = 1'b0;
    m_ptr    = 0;
    m_g      = 0;
    m_k      = 0;
    m_n      = 0;

    // Reset state
    do_reset(2);
    step();

    // Single request: requester 2, count 3
    req_v  = 4'b0100;
    ldv[2] = 4'd3;
    step();
    req_v = '0;
    wait_idle();
    step();

    // Zero count on requester 0
    req_v  = 4'b0001;
    ldv[0] = 4'd0;
    step();
    req_v = '0;
    wait_idle();
    step();

    // Round robin from a fresh pointer, all counts 1
    do_reset(1);
    for (int i = 0; i < NREQ; i++) ldv[i] = 4'd1;
    req_v      = 4'b1111;
    prev_grant = '0;
    exp_q      = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    obs_q.delete();
    for (int i = 0; i < 26; i++) begin
      step();
      if (bus.grant != '0 && prev_grant == '0) obs_q.push_back(bus.grant);
      prev_grant = bus.grant;
    end
    req_v = '0;
    wait_idle();
    chk("rr_count", 32'(obs_q.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      chk("rr_order", 32'(obs_q[i]), 32'(exp_q[i]));
    end
    step();

    // Mid-service reset on requester 1 with count 9
    req_v  = 4'b0010;
    ldv[1] = 4'd9;
    step();
    req_v = '0;
    repeat (3) step();
    do_reset(1);
    step();
    req_v  = 4'b1000;
    ldv[3] = 4'd2;
    step();
    chk("after_rst_grant3", 32'(bus.grant), 32'b1000);
    req_v = '0;
    wait_idle();
    step();
    req_v = 4'b1111;
    step();
    chk("after_rst_grant0", 32'(bus.grant), 32'b0001);
    req_v = '0;
    wait_idle();
    step();

    // Request dropped after grant; late request raised during COUNT
    req_v  = 4'b0010;
    ldv[1] = 4'd5;
    step();
    req_v = '0;
    repeat (3) step();
    req_v = 4'b1000;
    for (int i = 0; i < 12; i++) step();
    req_v = '0;
    wait_idle();
    step();

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        if ($urandom_range(0, 2) == 0) req_v = NREQ'($urandom_range(0, (1 << NREQ) - 1));
        for (int i = 0; i < NREQ; i++) begin
          if ($urandom_range(0, 3) == 0) ldv[i] = W'($urandom_range(0, (1 << W) - 1));
        end
        step();
      end
    end
    req_v = '0;
    wait_idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
